// File: rtl/shape_plotter.sv
// shape_plotter: queued pixel-primitive engine for the VGA path.
// Draw commands (filled RECT, down-right DIAG_R, down-left DIAG_L, FULL screen) are
// buffered in a DEPTH-entry FIFO and rasterised at one pixel per clock.
// Ports:
//   clk, resetn      - system clock, asynchronous active-low reset
//   flush            - synchronous abort: empties the FIFO and drops the current primitive
//   cmd_valid/ready  - command handshake; cmd_ready depends on FIFO occupancy only
//   cmd_mode/x/y/w/h/color - command fields (mode 0 RECT, 1 DIAG_R, 2 DIAG_L, 3 FULL)
//   plot, x_out, y_out, color_out - registered pixel stream for the VGA adapter
//   busy, done, count - activity flag, end-of-queue pulse, FIFO occupancy
// Build option: define SHAPE_PLOTTER_CLIP_EN to suppress off-screen pixels (they still take
// a cycle). Without it, coordinates wrap modulo 2^XW / 2^YW and every pixel is plotted.
module shape_plotter #(
   parameter int unsigned XW    = 8,
   parameter int unsigned YW    = 7,
   parameter int unsigned LW    = 7,
   parameter int unsigned CW    = 3,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned SCR_W = 160,
   parameter int unsigned SCR_H = 120
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     flush,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_mode,
   input  logic [XW-1:0]            cmd_x,
   input  logic [YW-1:0]            cmd_y,
   input  logic [LW-1:0]            cmd_w,
   input  logic [LW-1:0]            cmd_h,
   input  logic [CW-1:0]            cmd_color,
   output logic                     plot,
   output logic [XW-1:0]            x_out,
   output logic [YW-1:0]            y_out,
   output logic [CW-1:0]            color_out,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned CNTW = AW + 1;
   // Index counters must cover both the LW-wide length field and the full screen span.
   localparam int unsigned IW   = (LW > XW) ? LW : XW;
   localparam int unsigned JW   = (LW > YW) ? LW : YW;
   localparam int unsigned XS   = XW + 1;
   localparam int unsigned YS   = YW + 1;

   localparam logic [1:0] ModeRect  = 2'd0;
   localparam logic [1:0] ModeDiagR = 2'd1;
   localparam logic [1:0] ModeDiagL = 2'd2;
   localparam logic [1:0] ModeFull  = 2'd3;

   typedef struct packed {
      logic [1:0]    mode;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic [LW-1:0] w;
      logic [LW-1:0] h;
      logic [CW-1:0] color;
   } cmd_t;

   typedef enum logic [1:0] {StIdle, StLoad, StDraw, StDone} state_e;

   state_e          state_q, state_d;
   cmd_t            mem_q [DEPTH];
   cmd_t            mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0] count_q, count_d;
   cmd_t            cur_q, cur_d;
   logic [IW-1:0]   i_q, i_d;
   logic [JW-1:0]   j_q, j_d;
   logic            plot_q, plot_d, done_q, done_d;
   logic [XW-1:0]   x_q, x_d;
   logic [YW-1:0]   y_q, y_d;
   logic [CW-1:0]   color_q, color_d;

   cmd_t            cmd_in, head, src;
   logic            push, pop, emit, last, wrap, zero_len, on_screen;
   logic [IW-1:0]   w_last;
   logic [JW-1:0]   h_last;
   logic [XS-1:0]   px;
   logic [YS-1:0]   py;

   assign cmd_in    = {cmd_mode, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color};
   assign head      = mem_q[rd_ptr_q];
   assign cmd_ready = (count_q < CNTW'(DEPTH));

   always_comb begin
      state_d  = state_q;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cur_d    = cur_q;
      i_d      = i_q;
      j_d      = j_q;
      plot_d   = 1'b0;
      x_d      = x_q;
      y_d      = y_q;
      color_d  = color_q;
      pop      = 1'b0;
      emit     = 1'b0;
      push     = cmd_valid && cmd_ready && !flush;

      // End-of-primitive detection against the latched command; i_q/j_q index the pixel
      // currently on the outputs.
      w_last = IW'(cur_q.w) - IW'(1);
      h_last = JW'(cur_q.h) - JW'(1);
      case (cur_q.mode)
         ModeRect: begin
            wrap = (i_q == w_last);
            last = wrap && (j_q == h_last);
         end
         ModeFull: begin
            wrap = (i_q == IW'(SCR_W - 1));
            last = wrap && (j_q == JW'(SCR_H - 1));
         end
         default: begin
            wrap = 1'b0;
            last = (i_q == w_last);
         end
      endcase

      case (head.mode)
         ModeRect: zero_len = (head.w == '0) || (head.h == '0);
         ModeFull: zero_len = 1'b0;
         default:  zero_len = (head.w == '0);
      endcase

      case (state_q)
         StIdle: begin
            if (count_q != '0) state_d = StLoad;
         end
         StLoad: begin
            pop   = 1'b1;
            cur_d = head;
            i_d   = '0;
            j_d   = '0;
            if (zero_len) begin
               // After this pop, anything still queued goes straight to another LOAD.
               state_d = (count_q > CNTW'(1)) ? StLoad : StDone;
            end else begin
               state_d = StDraw;
               emit    = 1'b1;
            end
         end
         StDraw: begin
            if (last) begin
               state_d = (count_q != '0) ? StLoad : StDone;
            end else begin
               emit = 1'b1;
               if (wrap) begin
                  i_d = '0;
                  j_d = j_q + JW'(1);
               end else begin
                  i_d = i_q + IW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Pixel 0 comes straight from the FIFO head during LOAD, later pixels from cur_q.
      src = (state_q == StLoad) ? head : cur_q;
      case (src.mode)
         ModeRect: begin
            px = XS'(src.x) + XS'(i_d);
            py = YS'(src.y) + YS'(j_d);
         end
         ModeDiagR: begin
            px = XS'(src.x) + XS'(i_d);
            py = YS'(src.y) + YS'(i_d);
         end
         ModeDiagL: begin
            px = XS'(src.x) - XS'(i_d);
            py = YS'(src.y) + YS'(i_d);
         end
         default: begin
            px = XS'(i_d);
            py = YS'(j_d);
         end
      endcase

`ifdef SHAPE_PLOTTER_CLIP_EN
      on_screen = !px[XS-1] && !py[YS-1] &&
                  (px[XW-1:0] < XW'(SCR_W)) && (py[YW-1:0] < YW'(SCR_H));
`else
      on_screen = 1'b1;
`endif

      if (emit) begin
         plot_d  = on_screen;
         color_d = src.color;
         if (on_screen) begin
            x_d = px[XW-1:0];
            y_d = py[YW-1:0];
         end
      end

      if (push) begin
         mem_d[wr_ptr_q] = cmd_in;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CNTW'(push) - CNTW'(pop);

      done_d = (state_d == StDone);

      if (flush) begin
         state_d  = StIdle;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         plot_d   = 1'b0;
         done_d   = 1'b0;
         x_d      = x_q;
         y_d      = y_q;
         color_d  = color_q;
      end
   end

`ifndef SHAPE_PLOTTER_CLIP_EN
   // Sign bits only matter when clipping.
   logic unused_sign;
   assign unused_sign = px[XS-1] ^ py[YS-1];
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= StIdle;
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         cur_q    <= '0;
         i_q      <= '0;
         j_q      <= '0;
         plot_q   <= 1'b0;
         done_q   <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         color_q  <= '0;
      end else begin
         state_q  <= state_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         cur_q    <= cur_d;
         i_q      <= i_d;
         j_q      <= j_d;
         plot_q   <= plot_d;
         done_q   <= done_d;
         x_q      <= x_d;
         y_q      <= y_d;
         color_q  <= color_d;
      end
   end

   assign plot      = plot_q;
   assign x_out     = x_q;
   assign y_out     = y_q;
   assign color_out = color_q;
   assign done      = done_q;
   assign count     = count_q;
   assign busy      = (count_q != '0) || (state_q != StIdle);

endmodule

// File: doc/shape_plotter.md
Name: shape_plotter

Overview:
- Parametrised pixel-primitive engine for the VGA path; replaces per-shape hardwired counter blocks (gallows, dashes, body parts, screen wipe).
- Accepts queued draw commands: filled rectangle, down-right diagonal, down-left diagonal, full-screen fill.
- Emits one pixel per clock as registered x, y, colour plus a plot strobe for the VGA adapter.

Parameters:
XW, 8, x coordinate width
YW, 7, y coordinate width
LW, 7, width/height/length field width
CW, 3, colour width
DEPTH, 8, command FIFO entries (power of 2, >=2)
SCR_W, 160, visible screen width in pixels
SCR_H, 120, visible screen height in pixels

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
flush  in  1  synchronous abort: empty FIFO, drop current primitive
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept
cmd_mode  in  2  0 RECT, 1 DIAG_R, 2 DIAG_L, 3 FULL
cmd_x  in  XW  origin x
cmd_y  in  YW  origin y
cmd_w  in  LW  width (RECT) / length (DIAG)
cmd_h  in  LW  height (RECT only)
cmd_color  in  CW  colour
plot  out  1  pixel valid this cycle
x_out  out  XW  pixel x
y_out  out  YW  pixel y
color_out  out  CW  pixel colour
busy  out  1  FIFO non-empty or state != IDLE
done  out  1  one-cycle pulse when last queued primitive finishes
count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Async reset (resetn low): FIFO empty, state IDLE; plot=0, x_out=0, y_out=0, color_out=0, busy=0, done=0, count=0. cmd_ready is combinational from count only, so it is 1 during and after reset.
- FIFO push when cmd_valid&cmd_ready. cmd_ready = (count<DEPTH). A pop in the same cycle does not raise cmd_ready. Simultaneous push and pop leaves count unchanged.
- FSM states IDLE, LOAD, DRAW, DONE:
  - IDLE: FIFO non-empty -> LOAD.
  - LOAD: pop head, latch fields, clear i/j -> DRAW. If the primitive has zero pixels (RECT with w=0 or h=0, DIAG with w=0), skip DRAW and go to next-primitive selection.
  - DRAW: one pixel per cycle. After the last pixel: FIFO non-empty -> LOAD, else -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Latency: command pushed at edge E into an idle, empty engine -> LOAD after E+1 -> first plot=1 after E+2. Between primitives there is one LOAD bubble cycle (plot=0).
- Pixel sequences (i inner, j outer):
  - RECT: (x+i, y+j), i 0..w-1, j 0..h-1, row-major.
  - DIAG_R: (x+i, y+i), i 0..w-1.
  - DIAG_L: (x-i, y+i), i 0..w-1.
  - FULL: ignores x/y/w/h; (i, j), i 0..SCR_W-1, j 0..SCR_H-1.
- Arithmetic: coordinates computed at XW+1 / YW+1 bits signed. Clipping and wrap rules are under Optional Feature.
- color_out = latched cmd_color for every pixel of the primitive.
- flush (synchronous, beats everything but reset): FIFO emptied, state -> IDLE, plot=0 next cycle, no done pulse. A push in the same cycle as flush is discarded.
- plot, x_out, y_out, color_out are registered. x_out/y_out hold their last value when plot=0.

Optional Feature:
- Macro SHAPE_PLOTTER_CLIP_EN.
- Defined: a pixel is off-screen if x<0, x>=SCR_W, y<0 or y>=SCR_H. Off-screen pixels still consume their cycle, but plot=0 and x_out/y_out hold their previous value.
- Undefined: no clipping. Coordinates are truncated to XW/YW bits (modulo 2^XW, 2^YW) and plot=1 for every pixel.

Test Plan:
- RECT x=100 y=20 w=2 h=3 colour=1 -> six plots (100,20),(101,20),(100,21),(101,21),(100,22),(101,22) colour 1 on consecutive cycles, first plot 2 edges after accept; done pulses once, one cycle after the last plot.
- Push 9 RECTs back-to-back with DEPTH=8 while the engine is busy -> cmd_ready=0 once 8 are queued, 9th held until a pop; all 9 draw in order; a single done at the end.
- CLIP_EN, DIAG_L x=2 y=50 w=5 -> plots (2,50),(1,51),(0,52) then 2 cycles with plot=0. Without CLIP_EN -> additionally (255,53),(254,54).
- FULL colour=0 -> exactly 19200 plot pulses, first (0,0), last (159,119), then done.
- RECT w=0 queued ahead of RECT 1x1 at (5,5) -> no pixels from the first; single plot (5,5); one done.
- flush during the 3rd pixel of a 4x4 RECT with 2 commands queued -> plot=0 next cycle, count=0, busy=0, no done. Then resetn low mid-draw -> all outputs 0 immediately.
